// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared word/byte geometry and serializer FSM states
package uart_pkg;

    localparam int DATA_W         = 256;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } state_t;

endpackage

// File: rtl/word_fifo2.sv
// rtl/word_fifo2.sv - two-entry word FIFO with count and simultaneous push/pop
module word_fifo2 #(
    parameter int W = uart_pkg::DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    // Word storage; contents are don't-care until counted, so no reset
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/word_to_byte_tx.sv
// rtl/word_to_byte_tx.sv - buffers 256-bit words and streams them out as bytes; WORD_CKSUM_EN appends an XOR byte
module word_to_byte_tx #(
    parameter int DATA_W    = uart_pkg::DATA_W,
    parameter int BYTE_W    = uart_pkg::BYTE_W,
    parameter int MSB_FIRST = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_vld,
    input  logic              byte_rdy,
    output logic              word_done,
    output logic              busy
);

    import uart_pkg::state_t;
    import uart_pkg::IDLE;
    import uart_pkg::SEND;
`ifdef WORD_CKSUM_EN
    import uart_pkg::CKSUM;
`endif

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_byte_vld;
    logic                r_din_rdy;

    logic                w_push;
    logic                w_pop;
    logic                w_byte_hs;
    logic                w_last_data;
    logic [DATA_W-1:0]   w_head;
    logic [1:0]          w_fifo_cnt;
    logic [1:0]          w_cnt_nxt;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [BYTE_W-1:0]   w_sel_byte;

`ifdef WORD_CKSUM_EN
    logic [BYTE_W-1:0]   r_xor;
`endif

    assign w_push      = din_vld && r_din_rdy && !w_fifo_full;
    assign w_byte_hs   = r_byte_vld && byte_rdy;
    assign w_last_data = (r_idx == LAST_IDX);

`ifdef WORD_CKSUM_EN
    assign w_pop = w_byte_hs && (r_state == CKSUM);
`else
    assign w_pop = w_byte_hs && (r_state == SEND) && w_last_data;
`endif

    word_fifo2 #(
        .W(DATA_W)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_push),
        .i_din   (din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_cnt),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Occupancy after this cycle's push/pop, used to register ready and pick the next state
    always_comb begin
        w_cnt_nxt = w_fifo_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = w_fifo_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = w_fifo_cnt - 2'd1;
        end
    end

    assign w_sel_idx  = (MSB_FIRST != 0) ? (LAST_IDX - r_idx) : r_idx;
    assign w_sel_byte = w_head[w_sel_idx*BYTE_W +: BYTE_W];

    // Serializer FSM: byte index, byte-valid and input-ready all registered here
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_byte_vld <= 1'b0;
            r_din_rdy  <= 1'b0;
        end else begin
            r_din_rdy <= (w_cnt_nxt != 2'd2);
            if (w_byte_hs && (r_state == SEND)) begin
                r_idx <= w_last_data ? '0 : r_idx + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state    <= SEND;
                        r_byte_vld <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_byte_hs && w_last_data) begin
`ifdef WORD_CKSUM_EN
                        r_state <= CKSUM;
`else
                        r_state    <= (w_cnt_nxt != 2'd0) ? SEND : IDLE;
                        r_byte_vld <= (w_cnt_nxt != 2'd0);
`endif
                    end
                end
`ifdef WORD_CKSUM_EN
                CKSUM: begin
                    if (w_byte_hs) begin
                        r_state    <= (w_cnt_nxt != 2'd0) ? SEND : IDLE;
                        r_byte_vld <= (w_cnt_nxt != 2'd0);
                    end
                end
`endif
                default: begin
                    r_state    <= IDLE;
                    r_byte_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef WORD_CKSUM_EN
    // Running XOR of the current word's data bytes, cleared when its checksum byte leaves
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_xor <= '0;
        end else if (w_byte_hs) begin
            if (r_state == CKSUM) begin
                r_xor <= '0;
            end else begin
                r_xor <= r_xor ^ w_sel_byte;
            end
        end
    end
`endif

    // Output byte mux: head byte while sending, checksum in CKSUM, zero when idle
    always_comb begin
        byte_out = '0;
        if (r_state == SEND) begin
            byte_out = w_sel_byte;
        end
`ifdef WORD_CKSUM_EN
        else if (r_state == CKSUM) begin
            byte_out = r_xor;
        end
`endif
    end

    assign byte_vld  = r_byte_vld;
    assign din_rdy   = r_din_rdy;
    assign word_done = w_pop;
    assign busy      = !w_fifo_empty;

endmodule

// File: tb/tb_word_to_byte_tx.sv
// tb/tb_word_to_byte_tx.sv - scoreboard bench for word_to_byte_tx
module tb_word_to_byte_tx;

    localparam int DW = 256;
`ifdef WORD_CKSUM_EN
    localparam int PER = 33;
`else
    localparam int PER = 32;
`endif

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_vld = 1'b0;
    logic          din_rdy;
    logic [7:0]    byte_out;
    logic          byte_vld;
    logic          byte_rdy = 1'b0;
    logic          word_done;
    logic          busy;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_taken = 0;
    int done_cyc = -1;
    int rdy_mode = 0;
    int ph = 0;
    exp_t sb[$];

    logic          prev_stall = 1'b0;
    logic [7:0]    prev_b = '0;
    exp_t          e;
    int            acc, acc2, base, t;
    logic [DW-1:0] w, w2, w3;

    word_to_byte_tx dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .byte_out  (byte_out),
        .byte_vld  (byte_vld),
        .byte_rdy  (byte_rdy),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_k(input logic [DW-1:0] wd, input int k);
        logic [DW-1:0] s;
        s = wd >> (8 * (31 - k));
        return s[7:0];
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | DW'($urandom());
        return r;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sb_push_word(input logic [DW-1:0] wd);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 32; k++) begin
            sb.push_back('{b: byte_k(wd, k), last: (PER == 32 && k == 31)});
            x = x ^ byte_k(wd, k);
        end
        if (PER == 33) sb.push_back('{b: x, last: 1'b1});
    endtask

    task automatic push_word(input logic [DW-1:0] wd, output int acc_cyc);
        din = wd;
        din_vld = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 500; i++) begin
            if (din_rdy) begin
                sb_push_word(wd);
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        if (acc_cyc < 0) check("push_timeout", 0, 1);
        tick();
        din_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            tick();
            n = n + 1;
        end
        check("drain", (sb.size() == 0) && !busy, 1);
    endtask

    initial forever begin
        @(posedge sys_clk);
        #1;
        ph = (ph + 1) % 4;
        case (rdy_mode)
            0: byte_rdy = 1'b1;
            1: byte_rdy = (ph == 0) || (ph == 3);
            default: byte_rdy = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge sys_clk);
        if (sys_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", byte_vld, 1);
                check("hold_byte", byte_out, prev_b);
            end
            if (byte_vld && byte_rdy) begin
                n_taken = n_taken + 1;
                if (sb.size() == 0) begin
                    check("unexpected_byte_sb_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("byte", byte_out, e.b);
                    check("word_done", word_done, e.last);
                end
                if (word_done) done_cyc = cyc;
            end else begin
                check("word_done_no_hs", word_done, 0);
            end
            prev_stall = byte_vld && !byte_rdy;
            prev_b = byte_out;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1;
        rdy_mode = 0;
        repeat (3) tick();
        check("rst_din_rdy", din_rdy, 0);
        check("rst_byte_vld", byte_vld, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_word_done", word_done, 0);
        check("rst_busy", busy, 0);
        sys_rst = 1'b0;
        tick();
        check("din_rdy_after_rst", din_rdy, 1);
        check("idle_byte_vld", byte_vld, 0);

        w = '0;
        for (int k = 0; k < 32; k++) w = (w << 8) | DW'(k);
        push_word(w, acc);
        check("lat_vld", byte_vld, 1);
        check("lat_byte0", byte_out, 8'h00);
        wait_drain();
        check("done_cycle", done_cyc, acc + PER);

        w = {32{8'hA5}};
        push_word(w, acc);
        wait_drain();

        rdy_mode = 1;
        tick();
        push_word(rand_word(), acc);
        wait_drain();
        push_word(rand_word(), acc);
        wait_drain();

        rdy_mode = 2;
        tick();
        tick();
        w = rand_word();
        w2 = rand_word();
        w3 = rand_word();
        push_word(w, acc);
        push_word(w2, acc);
        check("full_din_rdy", din_rdy, 0);
        check("full_busy", busy, 1);
        din = w3;
        din_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_hold", din_rdy, 0);
            tick();
        end
        rdy_mode = 0;
        t = 0;
        while (!din_rdy && t < 200) begin
            tick();
            t = t + 1;
        end
        check("rdy_return_seen", din_rdy, 1);
        if (din_rdy) begin
            sb_push_word(w3);
            check("rdy_return_cycle", cyc, done_cyc + 1);
        end
        tick();
        din_vld = 1'b0;
        wait_drain();

        w = rand_word();
        w2 = rand_word();
        push_word(w, acc);
        repeat (PER - 1) tick();
        push_word(w2, acc2);
        check("b2b_accept_cycle", acc2, acc + PER);
        check("b2b_done_cycle", done_cyc, acc + PER);
        check("b2b_vld", byte_vld, 1);
        check("b2b_byte0", byte_out, byte_k(w2, 0));
        wait_drain();

        base = n_taken;
        push_word(rand_word(), acc);
        t = 0;
        while (n_taken < base + 11 && t < 200) begin
            tick();
            t = t + 1;
        end
        check("mid_word_taken", n_taken, base + 11);
        sys_rst = 1'b1;
        tick();
        check("midrst_byte_vld", byte_vld, 0);
        check("midrst_busy", busy, 0);
        check("midrst_byte_out", byte_out, 0);
        check("midrst_din_rdy", din_rdy, 0);
        sb.delete();
        sys_rst = 1'b0;
        tick();
        check("postrst_din_rdy", din_rdy, 1);
        check("postrst_byte_vld", byte_vld, 0);
        w = rand_word();
        push_word(w, acc);
        check("postrst_byte0", byte_out, byte_k(w, 0));
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
